// File: rtl/uart_calc_pkg.sv
// Shared definitions for the UART calculator: sequencer states, opcodes and ASCII codes.
// The calculator core imports this package as well.
package uart_calc_pkg;

    typedef enum logic [1:0] {
        S_A     = 2'd0,
        S_B     = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_SLASH = 8'h2F;
    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_UC    = 8'h43;
    localparam logic [7:0] CH_LC    = 8'h63;
    localparam logic [7:0] CH_SP    = 8'h20;

endpackage

// File: rtl/uart_ascii_classify.sv
// Combinational byte classifier: sorts a received ASCII byte into the classes the
// sequencer acts on and decodes operator and digit values.
module uart_ascii_classify
    import uart_calc_pkg::*;
(
    input  logic [7:0] rx_data,
    output logic       is_digit,
    output logic       is_op,
    output logic       is_term,
    output logic       is_clear,
    output logic       is_space,
    output logic [1:0] op_code,
    output logic [3:0] digit
);

    always_comb begin
        is_op    = 1'b0;
        is_term  = 1'b0;
        is_clear = 1'b0;
        is_space = 1'b0;
        op_code  = OP_ADD;
        digit    = rx_data[3:0];
        is_digit = (rx_data >= CH_0) && (rx_data <= CH_9);
        case (rx_data)
            CH_PLUS:      begin is_op = 1'b1; op_code = OP_ADD; end
            CH_MINUS:     begin is_op = 1'b1; op_code = OP_SUB; end
            CH_STAR:      begin is_op = 1'b1; op_code = OP_MUL; end
            CH_SLASH:     begin is_op = 1'b1; op_code = OP_DIV; end
            CH_EQ, CH_CR: is_term  = 1'b1;
            CH_UC, CH_LC: is_clear = 1'b1;
            CH_SP:        is_space = 1'b1;
            default:      ;
        endcase
    end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Parses "<A><op><B>=" from the UART byte stream into a calculator command and
// offers it to the core over valid/ready; flags malformed input and idle timeouts.
module uart_cmd_sequencer
    import uart_calc_pkg::*;
#(
    parameter int DIGITS_MAX  = 4,
    parameter int OPW         = 14,
    parameter int TIMEOUT_CYC = 100_000_000,
    parameter int TO_W        = 27
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [7:0]     rx_data,
    input  logic           rx_valid,
    input  logic           cmd_ready,
    output logic [OPW-1:0] op_a,
    output logic [OPW-1:0] op_b,
    output logic [1:0]     opcode,
    output logic           cmd_valid,
    output logic           err,
    output logic           busy
);

    localparam int DW = $clog2(DIGITS_MAX + 1);

    state_t          state_q, state_d;
    logic [OPW-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
    logic [1:0]      opcode_q, opcode_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            err_q, err_d;

    logic            c_digit, c_op, c_term, c_clear, c_space;
    logic [1:0]      c_opcode;
    logic [3:0]      c_val;
    logic [OPW-1:0]  acc_src, acc_nxt;
    logic            clr, fault;

    uart_ascii_classify u_cls (
        .rx_data  (rx_data),
        .is_digit (c_digit),
        .is_op    (c_op),
        .is_term  (c_term),
        .is_clear (c_clear),
        .is_space (c_space),
        .op_code  (c_opcode),
        .digit    (c_val)
    );

    // x10 as shift-add; the digit-count limit keeps the result inside OPW bits
    assign acc_src = (state_q == S_B) ? op_b_q : op_a_q;
    assign acc_nxt = OPW'(({4'b0, acc_src} << 3) + ({4'b0, acc_src} << 1) + (OPW+4)'(c_val));

    assign busy = (state_q != S_A) || (dcnt_q != '0);

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        opcode_d = opcode_q;
        dcnt_d   = dcnt_q;
        to_d     = to_q;
        err_d    = 1'b0;
        clr      = 1'b0;
        fault    = 1'b0;

        if (rx_valid) begin
            to_d = '0;
            case (state_q)
                S_A, S_B: begin
                    if (c_digit) begin
                        if (dcnt_q < DW'(DIGITS_MAX)) begin
                            if (state_q == S_A) op_a_d = acc_nxt;
                            else                op_b_d = acc_nxt;
                            dcnt_d = dcnt_q + 1'b1;
                        end else begin
                            fault = 1'b1;
                        end
                    end else if (c_op && state_q == S_A && dcnt_q != '0) begin
                        opcode_d = c_opcode;
                        dcnt_d   = '0;
                        state_d  = S_B;
                    end else if (c_term && state_q == S_B && dcnt_q != '0) begin
                        state_d = S_ISSUE;
                    end else if (c_clear) begin
                        clr = 1'b1;
                    end else if (!c_space) begin
                        fault = 1'b1;
                    end
                end
                // pending command is frozen; stray bytes are only reported
                default: err_d = 1'b1;
            endcase
        end else if (state_q == S_ISSUE) begin
            if (cmd_ready) clr = 1'b1;
        end else if (busy) begin
            if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
                fault = 1'b1;
                to_d  = '0;
            end else begin
                to_d = to_q + 1'b1;
            end
        end

        if (clr || fault) begin
            op_a_d   = '0;
            op_b_d   = '0;
            opcode_d = OP_ADD;
            dcnt_d   = '0;
            state_d  = S_A;
        end
        if (fault) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_A;
            op_a_q   <= '0;
            op_b_q   <= '0;
            opcode_q <= OP_ADD;
            dcnt_q   <= '0;
            to_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            opcode_q <= opcode_d;
            dcnt_q   <= dcnt_d;
            to_q     <= to_d;
            err_q    <= err_d;
        end
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign opcode    = opcode_q;
    assign cmd_valid = (state_q == S_ISSUE);
    assign err       = err_q;

endmodule
